turn_arbiter: RTL and testbench

TURN_ARBITER -- requirements
Module: turn_arbiter

---
 rtl/turn_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_turn_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/turn_arbiter.sv
// turn_arbiter: move sequencer for a two-player board game.
// Accepts one move at a time from the player whose turn it is, asks the
// board for an occupancy check, strobes the write, then evaluates the
// board for a win or a full board before handing the turn over.
// Optional feature: define TURN_TIMEOUT_EN to forfeit a turn after
// TIMEOUT_CYCLES idle cycles in a WAIT state.
module turn_arbiter #(
  parameter int          TIMEOUT_CYCLES = 25000000,
  parameter int          CNT_W          = 25,
  parameter logic [1:0]  FIRST_PLAYER   = 2'b01
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       play,
  input  logic       play2,
  input  logic [3:0] x_position,
  input  logic       illegal_move,
  input  logic       win,
  input  logic       no_space,
  output logic [1:0] cand_player,
  output logic [3:0] cand_position,
  output logic       wr_en,
  output logic [1:0] turn,
  output logic       reject,
  output logic       timeout,
  output logic [1:0] winner,
  output logic       game_over
);

  typedef enum logic [2:0] {
    WAIT_P1,
    WAIT_P2,
    CHECK,
    COMMIT,
    EVAL,
    DONE
  } state_t;

  localparam logic [1:0] PLAYER_1 = 2'b01;
  localparam logic [1:0] PLAYER_2 = 2'b10;
  localparam state_t FIRST_WAIT = (FIRST_PLAYER == PLAYER_2) ? WAIT_P2 : WAIT_P1;

  state_t     state;
  state_t     state_next;
  logic       play_q;
  logic       play2_q;
  logic       play_rise;
  logic       play2_rise;
  logic [1:0] mover;
  logic [1:0] mover_next;
  logic [3:0] cand_position_next;
  logic [1:0] winner_next;
  logic       expired;
  logic       position_bad;

  assign play_rise    = play  & ~play_q;
  assign play2_rise   = play2 & ~play2_q;
  assign position_bad = (cand_position == 4'd0) || (cand_position > 4'd9);

`ifdef TURN_TIMEOUT_EN
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_count;

  // Idle-cycle counter: runs only while waiting for a move, restarts whenever the state moves on
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_count <= '0;
    end else if (state_next != state) begin
      wait_count <= '0;
    end else if ((state == WAIT_P1) || (state == WAIT_P2)) begin
      wait_count <= wait_count + 1'b1;
    end
  end

  assign expired = ((state == WAIT_P1) || (state == WAIT_P2)) && (wait_count == LAST_COUNT);
`else
  assign expired = 1'b0;
`endif

  // State, button history and the latched move/result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FIRST_WAIT;
      mover         <= FIRST_PLAYER;
      cand_position <= 4'd0;
      winner        <= 2'b00;
      play_q        <= 1'b0;
      play2_q       <= 1'b0;
    end else begin
      state         <= state_next;
      mover         <= mover_next;
      cand_position <= cand_position_next;
      winner        <= winner_next;
      play_q        <= play;
      play2_q       <= play2;
    end
  end

  // Next-state selection and per-state outputs; an accepted press outranks an expiring turn
  always_comb begin
    state_next         = state;
    mover_next         = mover;
    cand_position_next = cand_position;
    winner_next        = winner;
    cand_player        = 2'b00;
    wr_en              = 1'b0;
    turn               = 2'b00;
    reject             = 1'b0;
    timeout            = 1'b0;
    game_over          = 1'b0;

    case (state)
      WAIT_P1: begin
        turn = PLAYER_1;
        if (play_rise) begin
          mover_next         = PLAYER_1;
          cand_position_next = x_position;
          state_next         = CHECK;
        end else if (expired) begin
          timeout    = 1'b1;
          state_next = WAIT_P2;
        end
      end

      WAIT_P2: begin
        turn = PLAYER_2;
        if (play2_rise) begin
          mover_next         = PLAYER_2;
          cand_position_next = x_position;
          state_next         = CHECK;
        end else if (expired) begin
          timeout    = 1'b1;
          state_next = WAIT_P1;
        end
      end

      CHECK: begin
        turn        = mover;
        cand_player = mover;
        if (illegal_move || position_bad) begin
          reject     = 1'b1;
          state_next = (mover == PLAYER_2) ? WAIT_P2 : WAIT_P1;
        end else begin
          state_next = COMMIT;
        end
      end

      COMMIT: begin
        turn       = mover;
        wr_en      = 1'b1;
        state_next = EVAL;
      end

      EVAL: begin
        turn = mover;
        if (win) begin
          winner_next = mover;
          state_next  = DONE;
        end else if (no_space) begin
          winner_next = 2'b00;
          state_next  = DONE;
        end else begin
          state_next = (mover == PLAYER_2) ? WAIT_P1 : WAIT_P2;
        end
      end

      DONE: begin
        game_over = 1'b1;
      end

      default: begin
        state_next = FIRST_WAIT;
      end
    endcase
  end

  // Parameter sanity: the timeout must fit the counter and the first mover must be a real player
  param_check: assert property (@(posedge clock)
    (CNT_W >= 1) &&
    (64'(TIMEOUT_CYCLES) >= 64'd1) &&
    (64'(TIMEOUT_CYCLES) < (64'd1 << CNT_W)) &&
    ((FIRST_PLAYER == PLAYER_1) || (FIRST_PLAYER == PLAYER_2)));

endmodule

// File: tb/tb_turn_arbiter.sv
// tb_turn_arbiter: self-checking bench for turn_arbiter.
// Strobe events (write, reject, timeout) are predicted into a queue when a
// press is driven and matched, including their cycle, when the DUT shows them.
module tb_turn_arbiter;

  localparam logic [2:0] EV_WR  = 3'b100;
  localparam logic [2:0] EV_REJ = 3'b010;
  localparam logic [2:0] EV_TO  = 3'b001;

  typedef struct {
    logic [2:0] kind;
    int         cyc;
    logic [3:0] pos;
    logic [1:0] player;
  } ev_t;

  logic       clock        = 1'b0;
  logic       reset        = 1'b1;
  logic       play         = 1'b0;
  logic       play2        = 1'b0;
  logic [3:0] x_position   = 4'd0;
  logic       illegal_move = 1'b0;
  logic       win          = 1'b0;
  logic       no_space     = 1'b0;
  logic [1:0] cand_player;
  logic [3:0] cand_position;
  logic       wr_en;
  logic [1:0] turn;
  logic       reject;
  logic       timeout;
  logic [1:0] winner;
  logic       game_over;

  int   tests  = 0;
  int   fails  = 0;
  int   cyc    = 0;
  bit   mon_en = 1'b0;
  ev_t  sb[$];
  ev_t  mon_ev;

  int         m_turn   = 1;
  bit         m_done   = 1'b0;
  logic [1:0] m_winner = 2'b00;

  turn_arbiter #(
    .TIMEOUT_CYCLES (8),
    .CNT_W          (25),
    .FIRST_PLAYER   (2'b01)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .play          (play),
    .play2         (play2),
    .x_position    (x_position),
    .illegal_move  (illegal_move),
    .win           (win),
    .no_space      (no_space),
    .cand_player   (cand_player),
    .cand_position (cand_position),
    .wr_en         (wr_en),
    .turn          (turn),
    .reject        (reject),
    .timeout       (timeout),
    .winner        (winner),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;

  // Cycle index: value k means "between posedge k and posedge k+1"
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic doReset();
    step();
    reset = 1'b1;
    step();
    step();
    reset    = 1'b0;
    m_turn   = 1;
    m_done   = 1'b0;
    m_winner = 2'b00;
  endtask

  function automatic logic [1:0] playerCode(input int p);
    return (p == 2) ? 2'b10 : 2'b01;
  endfunction

  // One press: buttons high for one cycle, board inputs held until the move has been evaluated
  task automatic applyStimulus(input logic p1, input logic p2, input logic [3:0] pos,
                               input logic ill, input logic w, input logic ns);
    int         k;
    bit         taken;
    logic [1:0] who;
    step();
    k            = cyc;
    play         = p1;
    play2        = p2;
    x_position   = pos;
    illegal_move = ill;
    win          = w;
    no_space     = ns;
    who          = playerCode(m_turn);
    taken        = !m_done && ((m_turn == 1 && p1) || (m_turn == 2 && p2));
    if (taken) begin
      if (ill || pos == 4'd0 || pos > 4'd9) begin
        sb.push_back('{EV_REJ, k + 1, pos, who});
      end else begin
        sb.push_back('{EV_WR, k + 2, pos, who});
        if (w) begin
          m_done   = 1'b1;
          m_winner = who;
        end else if (ns) begin
          m_done   = 1'b1;
          m_winner = 2'b00;
        end else begin
          m_turn = (m_turn == 1) ? 2 : 1;
        end
      end
    end
    step();
    play  = 1'b0;
    play2 = 1'b0;
    checkOutput("cand_player", 32'(cand_player), 32'(taken ? who : 2'b00));
    step();
    step();
    step();
    illegal_move = 1'b0;
    win          = 1'b0;
    no_space     = 1'b0;
    checkOutput("turn", 32'(turn), 32'(m_done ? 2'b00 : playerCode(m_turn)));
    checkOutput("game_over", 32'(game_over), 32'(m_done));
    checkOutput("winner", 32'(winner), 32'(m_winner));
  endtask

  // Match every strobe the DUT shows against the oldest prediction
  always @(negedge clock) begin
    if (mon_en && (wr_en || reject || timeout)) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_event", 32'({wr_en, reject, timeout}), 32'd0);
      end else begin
        mon_ev = sb.pop_front();
        checkOutput("ev_kind", 32'({wr_en, reject, timeout}), 32'(mon_ev.kind));
        checkOutput("ev_cycle", 32'(cyc), 32'(mon_ev.cyc));
        checkOutput("ev_player", 32'(turn), 32'(mon_ev.player));
        if (mon_ev.kind != EV_TO)
          checkOutput("ev_pos", 32'(cand_position), 32'(mon_ev.pos));
      end
    end
  end

  initial begin
    int k;
    int r;

    doReset();
    mon_en = 1'b1;
    checkOutput("rst_turn", 32'(turn), 32'(2'b01));
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_reject", 32'(reject), 32'd0);
    checkOutput("rst_timeout", 32'(timeout), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    checkOutput("rst_winner", 32'(winner), 32'd0);
    checkOutput("rst_cand_player", 32'(cand_player), 32'd0);
    checkOutput("rst_cand_position", 32'(cand_position), 32'd0);

    applyStimulus(1'b1, 1'b0, 4'd5,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 4'd3,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd5,  1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd12, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd2,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, 4'd9,  1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'd7,  1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'd4,  1'b0, 1'b0, 1'b0);

    // Reset landing on the edge that closes the write cycle
    doReset();
    step();
    k          = cyc;
    play       = 1'b1;
    x_position = 4'd4;
    sb.push_back('{EV_WR, k + 2, 4'd4, 2'b01});
    step();
    play = 1'b0;
    step();
    reset = 1'b1;
    step();
    checkOutput("commit_rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("commit_rst_turn", 32'(turn), 32'(2'b01));
    checkOutput("commit_rst_game_over", 32'(game_over), 32'd0);
    checkOutput("commit_rst_cand_pos", 32'(cand_position), 32'd0);
    reset    = 1'b0;
    m_turn   = 1;
    m_done   = 1'b0;
    m_winner = 2'b00;

    applyStimulus(1'b1, 1'b0, 4'd1, 1'b0, 1'b0, 1'b1);
    doReset();
    applyStimulus(1'b1, 1'b0, 4'd8, 1'b0, 1'b1, 1'b0);

`ifdef TURN_TIMEOUT_EN
    // Idle first player forfeits in the eighth waiting cycle
    doReset();
    r = cyc;
    sb.push_back('{EV_TO, r + 7, 4'd0, 2'b01});
    repeat (9) step();
    checkOutput("turn_after_timeout", 32'(turn), 32'(2'b10));
    // A press arriving in the expiry cycle is taken instead
    doReset();
    repeat (6) step();
    applyStimulus(1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 1'b0);
`else
    doReset();
    repeat (40) step();
    checkOutput("idle_turn", 32'(turn), 32'(2'b01));
    checkOutput("idle_timeout", 32'(timeout), 32'd0);
`endif

    step();
    step();
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    r = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    fails++;
    $display("[TB] FAIL watchdog: got cycle %0d, expected run to complete", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
